data_mem_responder: RTL and testbench

//   Data-memory responder for the load/store stage of the pipelined datapath.
//   The datapath initiates one load or store per request. This block accepts it,

---
 rtl/data_mem_responder.sv | 199 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Load/store responder for the pipelined datapath's memory stage. It accepts
//   one request at a time. After LATENCY cycles it performs an RV32I
//   byte/half/word access on an internal word memory and emits a one-cycle
//   response pulse. Misaligned, out-of-range and illegal-funct3 requests are
//   answered with resp_err=1 and leave memory untouched.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-high reset (control state only)
//   req_valid   request present
//   req_ready   high in IDLE: a request is accepted on the next edge
//   req_write   1 = store, 0 = load
//   req_addr    byte address
//   req_wdata   store data (low bytes used for sb/sh)
//   req_funct3  RV32I funct3 of the load/store
//   resp_valid  one-cycle response pulse
//   resp_rdata  extended load result; 0 outside RESP, for stores and errors
//   resp_err    request rejected (qualified by resp_valid)
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  count_reg, count_next;

  logic        write_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  funct3_reg;

  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] rd_word_reg;

  // Rejection rules shared by the commit path and the response path.
  function automatic logic req_error(input logic write, input logic [31:0] addr,
                                     input logic [2:0] f3);
    logic illegal;
    logic misaligned;
    logic out_of_range;
    if (write) illegal = (f3 > 3'b010);
    else       illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    misaligned   = ((f3[1:0] == 2'b01) && addr[0]) ||
                   ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    out_of_range = (addr >> (ADDR_WIDTH + 2)) != 32'd0;
    return illegal || misaligned || out_of_range;
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready  = 1'b1;
        count_next = 4'd0;
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = BUSY;
            count_next = 4'd1;
          end
        end
      end
      BUSY: begin
        if (count_reg == 4'(LATENCY - 1)) begin
          state_next = RESP;
          count_next = 4'd0;
        end else begin
          count_next = count_reg + 4'd1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------ request latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_reg  <= 1'b0;
      addr_reg   <= 32'd0;
      wdata_reg  <= 32'd0;
      funct3_reg <= 3'd0;
    end else if (state_reg == IDLE && req_valid) begin
      write_reg  <= req_write;
      addr_reg   <= req_addr;
      wdata_reg  <= req_wdata;
      funct3_reg <= req_funct3;
    end
  end

  // With LATENCY=1 the commit edge is also the accepting edge, so the
  // commit path reads the live inputs while in IDLE and the latch otherwise.
  logic        cur_write;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [2:0]  cur_funct3;
  logic        cur_err;
  logic        commit;
  logic [ADDR_WIDTH-1:0] cur_idx;

  assign cur_write  = (state_reg == IDLE) ? req_write  : write_reg;
  assign cur_addr   = (state_reg == IDLE) ? req_addr   : addr_reg;
  assign cur_wdata  = (state_reg == IDLE) ? req_wdata  : wdata_reg;
  assign cur_funct3 = (state_reg == IDLE) ? req_funct3 : funct3_reg;
  assign cur_err    = req_error(cur_write, cur_addr, cur_funct3);
  assign cur_idx    = cur_addr[ADDR_WIDTH+1:2];
  // Edge that enters RESP; reset held high on this edge cancels the commit.
  assign commit     = (state_next == RESP) && (state_reg != RESP) && !reset;

  // Byte-lane enables and lane data: sb replicates the byte, sh the half.
  logic [3:0]  lane_en;
  logic [31:0] lane_data;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_en[gi] =
        (cur_funct3[1:0] == 2'b00) ? (cur_addr[1:0] == 2'(gi)) :
        (cur_funct3[1:0] == 2'b01) ? (cur_addr[1] == 1'(gi / 2)) : 1'b1;
      assign lane_data[8*gi +: 8] =
        (cur_funct3[1:0] == 2'b00) ? cur_wdata[7:0] :
        (cur_funct3[1:0] == 2'b01) ? cur_wdata[8*(gi%2) +: 8] :
                                     cur_wdata[8*gi +: 8];
    end
  endgenerate

  // Memory: byte-lane write and registered read, both on the commit edge.
  always_ff @(posedge clk) begin
    if (commit) begin
      if (cur_write && !cur_err) begin
        for (int b = 0; b < 4; b++) begin
          if (lane_en[b]) mem[cur_idx][8*b +: 8] <= lane_data[8*b +: 8];
        end
      end
      rd_word_reg <= mem[cur_idx];
    end
  end

  // ----------------------------------------------------------- response
  logic        resp_fault;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] byte_shift;

  assign resp_fault = req_error(write_reg, addr_reg, funct3_reg);
  assign byte_shift = rd_word_reg >> {addr_reg[1:0], 3'b000};
  assign byte_sel   = byte_shift[7:0];
  assign half_sel   = addr_reg[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];
  assign resp_err   = (state_reg == RESP) && resp_fault;

  always_comb begin
    resp_rdata = 32'd0;
    if (state_reg == RESP && !write_reg && !resp_fault) begin
      case (funct3_reg)
        3'b000:  resp_rdata = {{24{byte_sel[7]}}, byte_sel};
        3'b001:  resp_rdata = {{16{half_sel[15]}}, half_sel};
        3'b010:  resp_rdata = rd_word_reg;
        3'b100:  resp_rdata = {24'd0, byte_sel};
        3'b101:  resp_rdata = {16'd0, half_sel};
        default: resp_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder (ADDR_WIDTH=10, LATENCY=2).
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int tests;
  int fails;

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE (called 1 time unit after a rising edge)
  // and check the fixed LATENCY=2 response timing and payload.
  task automatic transact(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3,
                          input logic [31:0] exp_rd, input logic exp_err);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = wd;
    req_funct3 = f3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "/busy_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "/busy_ready"}, 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check({tag, "/resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "/rdata"}, resp_rdata, exp_rd);
    check({tag, "/err"}, 32'(resp_err), 32'(exp_err));
    @(posedge clk); #1;
    check({tag, "/after_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "/after_ready"}, 32'(req_ready), 32'd1);
    $display("[TB] %s addr=%h rdata=%h err=%0b", tag, a, exp_rd, exp_err);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_funct3 = 3'd0;

    // Reset state
    #12;
    check("reset/ready", 32'(req_ready), 32'd1);
    check("reset/valid", 32'(resp_valid), 32'd0);
    check("reset/rdata", resp_rdata, 32'd0);
    check("reset/err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Word store then load
    transact("sw_10", 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
    transact("lw_10", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);

    // Extensions
    transact("lb_13",  1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFFDE, 1'b0);
    transact("lbu_13", 1'b0, 32'h13, 32'h0, 3'b100, 32'h000000DE, 1'b0);
    transact("lh_10",  1'b0, 32'h10, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0);
    transact("lhu_12", 1'b0, 32'h12, 32'h0, 3'b101, 32'h0000DEAD, 1'b0);

    // Partial stores
    transact("sb_11",  1'b1, 32'h11, 32'h12345677, 3'b000, 32'h0, 1'b0);
    transact("lw_sb",  1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD77EF, 1'b0);
    transact("sh_12",  1'b1, 32'h12, 32'hAAAA5555, 3'b001, 32'h0, 1'b0);
    transact("lw_sh",  1'b0, 32'h10, 32'h0, 3'b010, 32'h555577EF, 1'b0);

    // Errors
    transact("err_lw12",   1'b0, 32'h12,   32'h0, 3'b010, 32'h0, 1'b1);
    transact("err_sh13",   1'b1, 32'h13,   32'hFFFFFFFF, 3'b001, 32'h0, 1'b1);
    transact("err_lw1000", 1'b0, 32'h1000, 32'h0, 3'b010, 32'h0, 1'b1);
    transact("err_ld011",  1'b0, 32'h10,   32'h0, 3'b011, 32'h0, 1'b1);
    transact("err_st011",  1'b1, 32'h10,   32'h0, 3'b011, 32'h0, 1'b1);
    transact("err_st100",  1'b1, 32'h10,   32'h0, 3'b100, 32'h0, 1'b1);
    transact("err_ld110",  1'b0, 32'h10,   32'h0, 3'b110, 32'h0, 1'b1);
    transact("lw_after_err", 1'b0, 32'h10, 32'h0, 3'b010, 32'h555577EF, 1'b0);

    // Top word of memory
    transact("sw_ffc", 1'b1, 32'hFFC, 32'h01020304, 3'b010, 32'h0, 1'b0);
    transact("lw_ffc", 1'b0, 32'hFFC, 32'h0, 3'b010, 32'h01020304, 1'b0);
    transact("lw_10_top", 1'b0, 32'h10, 32'h0, 3'b010, 32'h555577EF, 1'b0);

    // Back-to-back: req_valid held high for three requests
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 32'h10;
    req_funct3 = 3'b010;
    for (int i = 0; i < 10; i++) begin
      logic exp_ready;
      logic exp_valid;
      @(posedge clk); #1;
      if (i == 6) req_valid = 1'b0;
      exp_ready = (i % 3 == 2);
      exp_valid = (i % 3 == 1) && (i < 9);
      if (i == 9) exp_ready = 1'b1;
      check($sformatf("b2b_ready_%0d", i), 32'(req_ready), 32'(exp_ready));
      check($sformatf("b2b_valid_%0d", i), 32'(resp_valid), 32'(exp_valid));
      if (exp_valid) check($sformatf("b2b_rdata_%0d", i), resp_rdata, 32'h555577EF);
      $display("[TB] b2b cycle %0d ready=%0b valid=%0b", i, req_ready, resp_valid);
    end

    // Reset one cycle after accepting a store
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 32'h10;
    req_wdata  = 32'h0;
    req_funct3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    check("rst_mid/valid", 32'(resp_valid), 32'd0);
    check("rst_mid/ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("rst_mid/hold_valid_%0d", i), 32'(resp_valid), 32'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_mid/rel_ready", 32'(req_ready), 32'd1);
    check("rst_mid/rel_valid", 32'(resp_valid), 32'd0);
    $display("[TB] reset mid-busy dropped sw @10");
    transact("lw_after_rst", 1'b0, 32'h10, 32'h0, 3'b010, 32'h555577EF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
